// File: rtl/stopwatch_counter.sv
// Stopwatch time-keeping core: four BCD digits (MM:SS) with run/stop,
// clear, and a manual adjust mode with a blinking selected field.
module stopwatch_counter (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       tick_1hz_i,
    input  logic       tick_2hz_i,
    input  logic       pause_p_i,
    input  logic       clear_p_i,
    input  logic       adj_i,
    input  logic       sel_i,
    output logic [3:0] minutes_tens_o,
    output logic [3:0] minutes_units_o,
    output logic [3:0] seconds_tens_o,
    output logic [3:0] seconds_units_o,
    output logic       running_o,
    output logic       rollover_o,
    output logic [3:0] blank_o
);

    typedef enum logic [1:0] {
        STOPPED = 2'd0,
        RUNNING = 2'd1,
        ADJUST  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] mt_q, mu_q, st_q, su_q;
    logic [3:0] mt_d, mu_d, st_d, su_d;
    logic       blink_q, blink_d;
    logic       running_q, running_d;
    logic       rollover_q, rollover_d;
    logic [3:0] blank_q, blank_d;

    always_comb begin
        state_d    = state_q;
        mt_d       = mt_q;
        mu_d       = mu_q;
        st_d       = st_q;
        su_d       = su_q;
        blink_d    = blink_q;
        rollover_d = 1'b0;

        if (state_q == ADJUST && tick_2hz_i) begin
            blink_d = ~blink_q;
        end

        if (clear_p_i) begin
            mt_d = 4'd0;
            mu_d = 4'd0;
            st_d = 4'd0;
            su_d = 4'd0;
            if (state_q != ADJUST) begin
                state_d = STOPPED;
            end
        end else begin
            // Increments are decided by the pre-edge state; ">=" keeps any
            // digit from ever leaving its legal BCD range.
            if (state_q == RUNNING && tick_1hz_i) begin
                if (su_q >= 4'd9) begin
                    su_d = 4'd0;
                    if (st_q >= 4'd5) begin
                        st_d = 4'd0;
                        if (mu_q >= 4'd9) begin
                            mu_d = 4'd0;
                            if (mt_q >= 4'd9) begin
                                mt_d       = 4'd0;
                                rollover_d = 1'b1;
                            end else begin
                                mt_d = mt_q + 4'd1;
                            end
                        end else begin
                            mu_d = mu_q + 4'd1;
                        end
                    end else begin
                        st_d = st_q + 4'd1;
                    end
                end else begin
                    su_d = su_q + 4'd1;
                end
            end else if (state_q == ADJUST && tick_2hz_i) begin
                if (sel_i) begin
                    if (su_q >= 4'd9) begin
                        su_d = 4'd0;
                        st_d = (st_q >= 4'd5) ? 4'd0 : st_q + 4'd1;
                    end else begin
                        su_d = su_q + 4'd1;
                    end
                end else begin
                    if (mu_q >= 4'd9) begin
                        mu_d = 4'd0;
                        mt_d = (mt_q >= 4'd9) ? 4'd0 : mt_q + 4'd1;
                    end else begin
                        mu_d = mu_q + 4'd1;
                    end
                end
            end

            if (adj_i) begin
                state_d = ADJUST;
            end else if (state_q == ADJUST) begin
                state_d = STOPPED;
                blink_d = 1'b0;
            end else if (pause_p_i) begin
                state_d = (state_q == RUNNING) ? STOPPED : RUNNING;
            end
        end

        running_d = (state_d == RUNNING);
        if (state_d == ADJUST && blink_d) begin
            blank_d = sel_i ? 4'b0011 : 4'b1100;
        end else begin
            blank_d = 4'b0000;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q    <= STOPPED;
            mt_q       <= 4'd0;
            mu_q       <= 4'd0;
            st_q       <= 4'd0;
            su_q       <= 4'd0;
            blink_q    <= 1'b0;
            running_q  <= 1'b0;
            rollover_q <= 1'b0;
            blank_q    <= 4'b0000;
        end else begin
            state_q    <= state_d;
            mt_q       <= mt_d;
            mu_q       <= mu_d;
            st_q       <= st_d;
            su_q       <= su_d;
            blink_q    <= blink_d;
            running_q  <= running_d;
            rollover_q <= rollover_d;
            blank_q    <= blank_d;
        end
    end

    assign minutes_tens_o  = mt_q;
    assign minutes_units_o = mu_q;
    assign seconds_tens_o  = st_q;
    assign seconds_units_o = su_q;
    assign running_o       = running_q;
    assign rollover_o      = rollover_q;
    assign blank_o         = blank_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter; time is compared as a packed
// 16-bit MM:SS BCD word.
module tb_stopwatch_counter;

    logic       clk_i = 1'b0;
    logic       reset_i = 1'b0;
    logic       tick_1hz_i = 1'b0;
    logic       tick_2hz_i = 1'b0;
    logic       pause_p_i = 1'b0;
    logic       clear_p_i = 1'b0;
    logic       adj_i = 1'b0;
    logic       sel_i = 1'b0;
    logic [3:0] minutes_tens_o, minutes_units_o, seconds_tens_o, seconds_units_o;
    logic       running_o, rollover_o;
    logic [3:0] blank_o;

    int n_checks = 0;
    int n_errors = 0;
    logic ro_seen;

    stopwatch_counter dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .tick_1hz_i      (tick_1hz_i),
        .tick_2hz_i      (tick_2hz_i),
        .pause_p_i       (pause_p_i),
        .clear_p_i       (clear_p_i),
        .adj_i           (adj_i),
        .sel_i           (sel_i),
        .minutes_tens_o  (minutes_tens_o),
        .minutes_units_o (minutes_units_o),
        .seconds_tens_o  (seconds_tens_o),
        .seconds_units_o (seconds_units_o),
        .running_o       (running_o),
        .rollover_o      (rollover_o),
        .blank_o         (blank_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [15:0] tm();
        return {minutes_tens_o, minutes_units_o, seconds_tens_o, seconds_units_o};
    endfunction

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic tick1();
        tick_1hz_i = 1'b1;
        cyc();
        tick_1hz_i = 1'b0;
    endtask

    task automatic tick2();
        tick_2hz_i = 1'b1;
        cyc();
        tick_2hz_i = 1'b0;
    endtask

    task automatic pause();
        pause_p_i = 1'b1;
        cyc();
        pause_p_i = 1'b0;
    endtask

    task automatic do_reset();
        reset_i = 1'b0;
        cyc();
        reset_i = 1'b1;
    endtask

    initial begin
        cyc();
        cyc();
        reset_i = 1'b1;
        check("reset_time", tm(), 16'h0000);
        check("reset_running", running_o, 0);
        check("reset_rollover", rollover_o, 0);
        check("reset_blank", blank_o, 4'b0000);

        // Run 61 seconds
        pause();
        check("start_running", running_o, 1);
        ro_seen = 1'b0;
        for (int i = 0; i < 61; i++) begin
            tick1();
            ro_seen |= rollover_o;
        end
        check("run61_time", tm(), 16'h0101);
        check("run61_running", running_o, 1);
        check("run61_no_rollover", ro_seen, 0);

        // Clear from RUNNING, then preload 99:58 via adjust
        clear_p_i = 1'b1;
        cyc();
        clear_p_i = 1'b0;
        check("clear_time", tm(), 16'h0000);
        check("clear_stops", running_o, 0);
        adj_i = 1'b1;
        sel_i = 1'b0;
        cyc();
        check("adj_entry_blank", blank_o, 4'b0000);
        for (int i = 0; i < 99; i++) tick2();
        check("adj_min99", tm(), 16'h9900);
        check("adj_min_blank", blank_o, 4'b1100);
        sel_i = 1'b1;
        for (int i = 0; i < 58; i++) tick2();
        check("adj_9958", tm(), 16'h9958);
        check("adj_9958_blank", blank_o, 4'b0011);
        pause();
        check("pause_ignored_adj", running_o, 0);
        adj_i = 1'b0;
        cyc();
        check("adj_exit_blank", blank_o, 4'b0000);
        check("adj_exit_stopped", running_o, 0);
        pause();
        tick1();
        check("wrap_9959", tm(), 16'h9959);
        check("wrap_pre_rollover", rollover_o, 0);
        tick1();
        check("wrap_0000", tm(), 16'h0000);
        check("wrap_rollover", rollover_o, 1);
        check("wrap_running", running_o, 1);
        cyc();
        check("wrap_rollover_1cyc", rollover_o, 0);

        // Pause together with a tick while RUNNING
        for (int i = 0; i < 9; i++) tick1();
        check("run_0009", tm(), 16'h0009);
        pause_p_i = 1'b1;
        tick1();
        pause_p_i = 1'b0;
        check("pause_tick_time", tm(), 16'h0010);
        check("pause_tick_stopped", running_o, 0);
        tick1();
        check("stopped_tick_ignored", tm(), 16'h0010);

        // Pause together with a tick while STOPPED: starts without counting
        pause_p_i = 1'b1;
        tick1();
        pause_p_i = 1'b0;
        check("start_tick_time", tm(), 16'h0010);
        check("start_tick_running", running_o, 1);

        // Adjust seconds: 61 ticks, blank alternates
        do_reset();
        adj_i = 1'b1;
        sel_i = 1'b1;
        cyc();
        for (int i = 1; i <= 61; i++) begin
            tick2();
            check("sec_blink", blank_o, (i % 2) ? 4'b0011 : 4'b0000);
        end
        check("adj_sec61", tm(), 16'h0001);

        // Adjust minutes: 101 ticks, then clear stays in ADJUST
        do_reset();
        adj_i = 1'b1;
        sel_i = 1'b0;
        cyc();
        for (int i = 0; i < 101; i++) tick2();
        check("adj_min101", tm(), 16'h0100);
        clear_p_i = 1'b1;
        tick2();
        clear_p_i = 1'b0;
        check("adj_clear_time", tm(), 16'h0000);
        tick2();
        check("adj_clear_still_adj", tm(), 16'h0100);
        adj_i = 1'b0;
        cyc();
        check("adj_off_blank", blank_o, 4'b0000);
        check("adj_off_running", running_o, 0);
        tick2();
        check("stopped_tick2_ignored", tm(), 16'h0100);

        // Reset overrides everything mid-count
        do_reset();
        adj_i = 1'b1;
        sel_i = 1'b0;
        cyc();
        for (int i = 0; i < 12; i++) tick2();
        sel_i = 1'b1;
        for (int i = 0; i < 34; i++) tick2();
        adj_i = 1'b0;
        cyc();
        pause();
        check("preset_1234", tm(), 16'h1234);
        check("preset_running", running_o, 1);
        reset_i = 1'b0;
        pause_p_i = 1'b1;
        tick_1hz_i = 1'b1;
        cyc();
        reset_i = 1'b1;
        pause_p_i = 1'b0;
        tick_1hz_i = 1'b0;
        check("rst_time", tm(), 16'h0000);
        check("rst_running", running_o, 0);
        check("rst_rollover", rollover_o, 0);
        check("rst_blank", blank_o, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
# stopwatch_counter

Time-keeping core of the stopwatch: holds elapsed time as four BCD digits (MM:SS, 00:00 to 99:59) and advances it on a one-second enable while running. It also supports pause/resume, clear, and a manual adjust mode. It sits directly upstream of the display multiplexer and drives that block's minutes_tens/minutes_units/seconds_tens/seconds_units inputs plus a per-digit blank mask. Tick enables come from the clock divider; button pulses come from the debouncers.

## Interface
- No parameters; all widths fixed.
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-low reset (sampled on rising clk; 0 = reset).
- tick_1hz  in  1  one-cycle enable, 1 Hz; advances time in RUNNING.
- tick_2hz  in  1  one-cycle enable, 2 Hz; adjust increment and blink toggle.
- pause_p  in  1  one-cycle pulse; toggles STOPPED/RUNNING.
- clear_p  in  1  one-cycle pulse; zeroes time.
- adj  in  1  level; 1 = adjust mode.
- sel  in  1  level; in adjust, 0 = minutes field, 1 = seconds field.
- minutes_tens  out  4  BCD 0-9.
- minutes_units  out  4  BCD 0-9.
- seconds_tens  out  4  BCD 0-5.
- seconds_units  out  4  BCD 0-9.
- running  out  1  1 while state = RUNNING.
- rollover  out  1  one-cycle pulse on 99:59 -> 00:00 wrap.
- blank  out  4  per-digit blank, bit0 = seconds_units … bit3 = minutes_tens; 1 = blank.

## Operation
- States: STOPPED (reset state), RUNNING, ADJUST.
- Event priority per cycle: reset > clear_p > adj > pause_p.
- Reset (reset=0): all digits 0, state STOPPED, running=0, rollover=0, blank=4'b0000, blink phase=0.
- clear_p:
  - All digits go to 0.
  - From STOPPED or RUNNING the state goes to STOPPED.
  - In ADJUST the state is unchanged.
  - A tick in the same cycle is ignored.
- adj=1 forces ADJUST from any state. When adj falls, the state goes to STOPPED and the blink phase goes to 0.
- pause_p (adj=0): STOPPED -> RUNNING, RUNNING -> STOPPED. It is ignored in ADJUST.
- RUNNING, on tick_1hz, increments time with BCD carries:
  - seconds_units 9 -> 0 carries into seconds_tens.
  - seconds_tens 5 -> 0 carries into minutes_units.
  - minutes_units 9 -> 0 carries into minutes_tens.
  - minutes_tens 9 -> 0 means 99:59 -> 00:00, asserts rollover for one cycle, and keeps RUNNING.
- ADJUST, on tick_2hz, increments only the selected field; there is no carry between fields:
  - sel=1: seconds 00..59, 59 -> 00.
  - sel=0: minutes 00..99, 99 -> 00.
- Blink (ADJUST only):
  - The blink phase toggles on every tick_2hz.
  - While the phase is 1, the selected pair is blanked: sel=1 gives blank=4'b0011, sel=0 gives blank=4'b1100.
  - blank=0 outside ADJUST.
- Digits never take illegal BCD values (seconds_tens ≤ 5, every digit ≤ 9) under any input sequence.

## Timing
- All outputs are registered. A tick or pulse sampled at edge N is reflected in the outputs after edge N; there is no combinational input-to-output path.
- A state change and a tick in the same cycle: the increment uses the pre-edge state.
  - pause_p together with tick_1hz in RUNNING counts the tick, then stops.
  - pause_p together with tick_1hz in STOPPED starts the state without counting that tick.
- rollover is high for exactly the cycle following the wrapping edge.
- sel changes take effect on the next tick_2hz; blank follows sel in the same cycle as the registered update.
- Reset mid-count or mid-adjust returns to 00:00 STOPPED on the next edge, regardless of the other inputs.

## Test plan
- Reset then pause_p, then 61 tick_1hz pulses -> 01:01, running=1, rollover never asserted.
- Preload 99:58 through adjust, adj=0, pause_p, then 2 tick_1hz -> 99:59 then 00:00 with a one-cycle rollover pulse, running stays 1.
- RUNNING at 00:09 with pause_p and tick_1hz in the same cycle -> 00:10 and running=0; a further tick_1hz leaves 00:10.
- adj=1, sel=1, 61 tick_2hz from 00:00 -> 00:01 (seconds wrap, minutes stay 00); blank alternates between 0011 and 0000 on each tick_2hz.
- adj=1, sel=0, 101 tick_2hz from 00:00 -> 01:00; then clear_p -> 00:00 and the state stays ADJUST; then adj=0 -> STOPPED and blank=0000.
- RUNNING at 12:34, drive reset=0 for one cycle with pause_p=1 -> 00:00, running=0, rollover=0, blank=0000.
